// File: rtl/conv2d_pkg.sv
// conv2d_pkg: shared constants, FSM encoding and window tap mapping.
// Used by conv_window_gen and its stream interface.
package conv2d_pkg;

   localparam int KERNEL_SIZE = 3;
   localparam int WIN_TAPS    = KERNEL_SIZE * KERNEL_SIZE;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // tap i = 3*dy + dx; w[0] top-left, w[4] centre
   function automatic int tap_idx(input int dy, input int dx);
      return KERNEL_SIZE * dy + dx;
   endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// conv_window_gen_if: valid/ready window stream to the MAC array.
// master drives valid/win/row/col/last, slave drives ready.
interface conv_window_gen_if
   import conv2d_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int IMG_W      = 16,
   parameter int IMG_H      = 16
);
   localparam int RW = $clog2(IMG_H);
   localparam int CW = $clog2(IMG_W);

   logic                           out_valid;
   logic                           out_ready;
   logic [WIN_TAPS*DATA_WIDTH-1:0] out_win;
   logic [RW-1:0]                  out_row;
   logic [CW-1:0]                  out_col;
   logic                           out_last;

   modport master (
      output out_valid, out_win, out_row, out_col, out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_win, out_row, out_col, out_last,
      output out_ready
   );

endinterface

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: DEPTH-deep shift delay line with shift enable.
// Ports: clk, rst_n, en (shift), din, dout (sample shifted in DEPTH steps ago).
module conv_line_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   logic [DATA_WIDTH-1:0] taps_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) taps_q[i] <= '0;
      end else if (en) begin
         taps_q[0] <= din;
         for (int i = 1; i < DEPTH; i++) taps_q[i] <= taps_q[i-1];
      end
   end

   assign dout = taps_q[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: streams a frame from BRAM, emits 3x3 same-padded windows.
// Ports: clk, rst_n, start/base_addr/busy/done, rd_en/rd_addr/rd_data, win stream.
module conv_window_gen
   import conv2d_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int IMG_W      = 16,
   parameter int IMG_H      = 16,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   output logic                  busy,
   output logic                  done,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   conv_window_gen_if.master     win
);

   localparam int DW    = DATA_WIDTH;
   localparam int NPIX  = IMG_W * IMG_H;
   localparam int NSTEP = NPIX + IMG_W + 1;
   localparam int KW    = $clog2(NSTEP + 1);
   localparam int IW    = $clog2(NPIX + 1);
   localparam int RW    = $clog2(IMG_H);
   localparam int CW    = $clog2(IMG_W);

   state_t state_q, state_d;

   logic [ADDR_WIDTH-1:0] base_q;
   logic [IW-1:0]         idx_q;
   logic [KW-1:0]         k_q;
   logic                  pend_q;
   logic [RW-1:0]         r_q;
   logic [CW-1:0]         c_q;

   logic [DW-1:0] raw_q [WIN_TAPS];
   logic [DW-1:0] raw_d [WIN_TAPS];
   logic [DW-1:0] col   [KERNEL_SIZE];

   logic                    valid_q;
   logic [WIN_TAPS*DW-1:0]  win_q, win_d;
   logic [RW-1:0]           row_q;
   logic [CW-1:0]           col_q;
   logic                    last_q;

   logic          advance, in_frame, step, emit, active;
   logic          r_top, r_bot, c_lft, c_rgt;
   logic [DW-1:0] sample, lb1_out, lb0_out;

   assign active   = (state_q == ST_RUN) || (state_q == ST_FLUSH);
   assign advance  = !valid_q || win.out_ready;
   assign in_frame = k_q < KW'(NPIX);
   // frame steps need their read returned; flush steps run free
   assign step     = advance && active &&
                     (in_frame ? pend_q : (k_q < KW'(NSTEP)));
   assign emit     = step && (k_q >= KW'(IMG_W + 1));
   assign sample   = in_frame ? rd_data : '0;

   assign rd_en   = advance && (state_q == ST_RUN) &&
                    (idx_q < IW'(NPIX));
   assign rd_addr = base_q + ADDR_WIDTH'(idx_q);

   assign busy = active;
   assign done = (state_q == ST_DONE);

   assign win.out_valid = valid_q;
   assign win.out_win   = win_q;
   assign win.out_row   = row_q;
   assign win.out_col   = col_q;
   assign win.out_last  = last_q;

   // lb1 holds row r+1 tail, lb0 row r
   conv_line_buffer #(.DATA_WIDTH(DW), .DEPTH(IMG_W)) u_lb1 (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (step),
      .din  (sample),
      .dout (lb1_out)
   );

   conv_line_buffer #(.DATA_WIDTH(DW), .DEPTH(IMG_W)) u_lb0 (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (step),
      .din  (lb1_out),
      .dout (lb0_out)
   );

   assign r_top = (r_q == '0);
   assign r_bot = (r_q == RW'(IMG_H - 1));
   assign c_lft = (c_q == '0);
   assign c_rgt = (c_q == CW'(IMG_W - 1));

   always_comb begin
      col[0] = lb0_out;
      col[1] = lb1_out;
      col[2] = sample;
      for (int dy = 0; dy < KERNEL_SIZE; dy++) begin
         for (int dx = 0; dx < KERNEL_SIZE; dx++) begin
            if (dx < KERNEL_SIZE - 1)
               raw_d[tap_idx(dy, dx)] = raw_q[tap_idx(dy, dx + 1)];
            else
               raw_d[tap_idx(dy, dx)] = col[dy];
         end
      end
   end

   // padding masks also strip row-wrap samples from the delay lines
   always_comb begin
      win_d = '0;
      for (int dy = 0; dy < KERNEL_SIZE; dy++) begin
         for (int dx = 0; dx < KERNEL_SIZE; dx++) begin
            if (!((r_top && dy == 0) || (r_bot && dy == 2) ||
                  (c_lft && dx == 0) || (c_rgt && dx == 2)))
               win_d[tap_idx(dy, dx)*DW +: DW] = raw_d[tap_idx(dy, dx)];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (start) state_d = ST_RUN;
         ST_RUN:   if (rd_en && idx_q == IW'(NPIX - 1)) state_d = ST_FLUSH;
         ST_FLUSH: if (valid_q && win.out_ready && last_q) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q <= '0;
         idx_q  <= '0;
         k_q    <= '0;
         pend_q <= 1'b0;
         r_q    <= '0;
         c_q    <= '0;
      end else if (state_q == ST_IDLE && start) begin
         base_q <= base_addr;
         idx_q  <= '0;
         k_q    <= '0;
         pend_q <= 1'b0;
         r_q    <= '0;
         c_q    <= '0;
      end else begin
         if (rd_en) idx_q <= idx_q + 1'b1;
         if (rd_en)     pend_q <= 1'b1;
         else if (step) pend_q <= 1'b0;
         if (step) k_q <= k_q + 1'b1;
         if (emit) begin
            if (c_rgt) begin
               c_q <= '0;
               r_q <= r_q + 1'b1;
            end else begin
               c_q <= c_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < WIN_TAPS; i++) raw_q[i] <= '0;
      end else if (step) begin
         for (int i = 0; i < WIN_TAPS; i++) raw_q[i] <= raw_d[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         win_q   <= '0;
         row_q   <= '0;
         col_q   <= '0;
         last_q  <= 1'b0;
      end else if (emit) begin
         valid_q <= 1'b1;
         win_q   <= win_d;
         row_q   <= r_q;
         col_q   <= c_q;
         last_q  <= r_bot && c_rgt;
      end else if (win.out_ready) begin
         valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: random-stimulus bench for conv_window_gen.
// BRAM word at address a holds a+1; windows compared against a pixel model.
module tb_conv_window_gen;

   localparam int DW = 8;
   localparam int W  = 4;
   localparam int H  = 4;
   localparam int AW = 10;
   localparam int N  = W * H;
   localparam int RW = $clog2(H);
   localparam int CW = $clog2(W);

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b1;
   logic          start     = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic          busy;
   logic          done;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data   = '0;

   conv_window_gen_if #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)) win_if ();

   conv_window_gen #(
      .DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .ADDR_WIDTH(AW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .base_addr(base_addr),
      .busy     (busy),
      .done     (done),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .win      (win_if.master)
   );

   always #5 clk = ~clk;

   // single-cycle BRAM read port; data holds while rd_en is low
   always @(posedge clk) if (rd_en) rd_data <= DW'(rd_addr + 1'b1);

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] pix(input int b, input int r,
                                         input int c);
      if (r < 0 || r >= H || c < 0 || c >= W) return '0;
      return DW'(b + r * W + c + 1);
   endfunction

   function automatic logic [9*DW-1:0] ref_win(input int b, input int p);
      logic [9*DW-1:0] w;
      int r, c;
      r = p / W;
      c = p % W;
      w = '0;
      for (int dy = 0; dy < 3; dy++)
         for (int dx = 0; dx < 3; dx++)
            w[(3*dy+dx)*DW +: DW] = pix(b, r + dy - 1, c + dx - 1);
      return w;
   endfunction

   function automatic logic [9*DW-1:0] pack9(input int v[9]);
      logic [9*DW-1:0] w;
      for (int i = 0; i < 9; i++) w[i*DW +: DW] = DW'(v[i]);
      return w;
   endfunction

   bit              mon_en     = 1'b0;
   bit              rmode      = 1'b0;
   int              exp_base   = 0;
   int              rd_cnt     = 0;
   int              win_cnt    = 0;
   int              first_rd   = -1;
   int              first_vld  = -1;
   int              last_hs    = -1;
   int              start_cyc  = 0;
   bit              prev_stall = 1'b0;
   logic [127:0]    prev_out   = '0;
   logic [127:0]    cur        = '0;
   logic [9*DW-1:0] got_win [N];

   initial begin
      win_if.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         win_if.out_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   always @(negedge clk) begin
      if (!mon_en) begin
         prev_stall = 1'b0;
      end else begin
         cur = 128'({win_if.out_last, win_if.out_col, win_if.out_row,
                     win_if.out_win});
         if (prev_stall) chk("stall_hold", cur, prev_out);
         if (rd_en) begin
            chk("rd_in_stall",
                128'(win_if.out_valid && !win_if.out_ready), 128'(0));
            chk("rd_addr", 128'(rd_addr), 128'(AW'(exp_base + rd_cnt)));
            if (rd_cnt == 0) first_rd = cyc;
            rd_cnt++;
         end
         if (win_if.out_valid && first_vld < 0) first_vld = cyc;
         if (win_if.out_valid && win_if.out_ready) begin
            if (win_cnt < N) begin
               chk("win_rc", 128'({win_if.out_row, win_if.out_col}),
                   128'({RW'(win_cnt / W), CW'(win_cnt % W)}));
               chk("win_last", 128'(win_if.out_last),
                   128'(win_cnt == N - 1));
               chk("win_data", 128'(win_if.out_win),
                   128'(ref_win(exp_base, win_cnt)));
               got_win[win_cnt] = win_if.out_win;
            end else begin
               chk("extra_win", 128'(win_cnt), 128'(N - 1));
            end
            if (win_if.out_last) last_hs = cyc;
            win_cnt++;
         end
         prev_stall = win_if.out_valid && !win_if.out_ready;
         prev_out   = cur;
      end
   end

   task automatic start_frame(input int b);
      @(posedge clk);
      #1;
      base_addr = AW'(b);
      start     = 1'b1;
      exp_base  = b;
      rd_cnt    = 0;
      win_cnt   = 0;
      first_rd  = -1;
      first_vld = -1;
      last_hs   = -1;
      start_cyc = cyc;
      mon_en    = 1'b1;
      @(posedge clk);
      #1;
      start     = 1'b0;
      base_addr = AW'($urandom);
      chk("busy_after_start", 128'(busy), 128'(1));
   endtask

   task automatic wait_done(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 2000 && !seen; i++) begin
         @(negedge clk);
         #1;
         seen = done;
      end
      chk({tag, "_done_seen"}, 128'(seen), 128'(1));
      if (seen) begin
         chk({tag, "_done_lat"}, 128'(cyc), 128'(last_hs + 1));
         chk({tag, "_rd_total"}, 128'(rd_cnt), 128'(N));
         chk({tag, "_win_total"}, 128'(win_cnt), 128'(N));
         @(negedge clk);
         #1;
         chk({tag, "_done_pulse"}, 128'({done, busy}), 128'(0));
      end
      mon_en = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk(tag, 128'({busy, done, rd_en, rd_addr, win_if.out_valid,
                     win_if.out_win, win_if.out_row, win_if.out_col,
                     win_if.out_last}), 128'(0));
   endtask

   initial begin
      bit seen;
      #2 rst_n = 1'b0;
      #1 chk_all_zero("reset_outs");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("idle_outs", 128'({busy, done, rd_en, win_if.out_valid}),
          128'(0));

      // basic frame, ready held high
      rmode = 1'b0;
      start_frame(0);
      wait_done("basic");
      chk("lat_first_rd", 128'(first_rd - start_cyc), 128'(1));
      chk("lat_first_vld", 128'(first_vld - start_cyc), 128'(W + 4));
      chk("w_0_0", 128'(got_win[0]), 128'(pack9('{0,0,0, 0,1,2, 0,5,6})));
      chk("w_1_1", 128'(got_win[5]),
          128'(pack9('{1,2,3, 5,6,7, 9,10,11})));
      chk("w_1_3", 128'(got_win[7]),
          128'(pack9('{3,4,0, 7,8,0, 11,12,0})));
      chk("w_2_0", 128'(got_win[8]),
          128'(pack9('{0,5,6, 0,9,10, 0,13,14})));
      chk("w_3_3", 128'(got_win[15]),
          128'(pack9('{11,12,0, 15,16,0, 0,0,0})));

      // backpressure
      rmode = 1'b1;
      start_frame(0);
      wait_done("bp");

      // offset frame with a start pulsed while busy
      start_frame(32);
      repeat (10) @(posedge clk);
      #1;
      start     = 1'b1;
      base_addr = AW'(100);
      @(posedge clk);
      #1 start = 1'b0;
      wait_done("offset");

      // reset mid-frame
      start_frame(0);
      seen = 1'b0;
      for (int i = 0; i < 2000 && !seen; i++) begin
         @(negedge clk);
         #1;
         seen = (win_cnt >= 5);
      end
      chk("mid_reach_win5", 128'(seen), 128'(1));
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1 chk_all_zero("mid_reset_outs");
      @(posedge clk);
      #1 rst_n = 1'b1;
      start_frame(0);
      wait_done("after_reset");

      // a couple of random-base frames
      for (int f = 0; f < 2; f++) begin
         start_frame(int'($urandom_range(0, 1000)));
         wait_done("rand_base");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
